// File: rtl/alu_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_op_sequencer
// Purpose  : Valid/ready front end for the combinational 16-bit ALU. It
//            latches a request, drives the ALU operand/select/shin inputs and
//            returns the captured result over a response handshake.
//            Multi-bit shifts run as repeated single-bit ALU passes.
// Options  : ALUSEQ_RSP_BYPASS_EN - accept a new request in the same cycle as
//            the response handshake, skipping the IDLE cycle.
// Revision : 1.0 - initial release
// ============================================================================
module alu_op_sequencer #(
  parameter int NBIT = 16,
  parameter int SHW  = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [2:0]      req_op_i,
  input  logic [NBIT-1:0] req_a_i,
  input  logic [NBIT-1:0] req_b_i,
  input  logic [SHW-1:0]  req_shamt_i,
  output logic [NBIT-1:0] alu_a_o,
  output logic [NBIT-1:0] alu_b_o,
  output logic [2:0]      alu_sel_o,
  output logic            alu_shin_o,
  input  logic [NBIT-1:0] alu_result_i,
  output logic            rsp_valid_o,
  input  logic            rsp_ready_i,
  output logic [NBIT-1:0] rsp_data_o,
  output logic            busy_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EXEC  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [2:0]      op_q, op_d;
  logic [NBIT-1:0] a_q, a_d;
  logic [NBIT-1:0] b_q, b_d;
  logic [NBIT-1:0] acc_q, acc_d;
  logic [SHW-1:0]  cnt_q, cnt_d;
  logic [NBIT-1:0] rsp_data_q, rsp_data_d;
  logic            is_shift;

  // State and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      op_q       <= 3'd0;
      a_q        <= '0;
      b_q        <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      rsp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  // Next-state, ALU drive and handshake outputs; the accept path is applied
  // last so that a bypass accept in RESP overrides the return to IDLE.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    rsp_data_d  = rsp_data_q;
    alu_a_o     = '0;
    alu_b_o     = '0;
    alu_sel_o   = 3'd0;
    alu_shin_o  = 1'b0;
    req_ready_o = 1'b0;
    rsp_valid_o = 1'b0;
    is_shift    = (req_op_i[2:1] == 2'b11);

    case (state_q)
      ST_IDLE: begin
        req_ready_o = 1'b1;
      end
      ST_EXEC: begin
        alu_a_o    = a_q;
        alu_b_o    = b_q;
        alu_sel_o  = op_q;
        rsp_data_d = alu_result_i;
        state_d    = ST_RESP;
      end
      ST_SHIFT: begin
        alu_a_o    = acc_q;
        alu_sel_o  = op_q;
        alu_shin_o = 1'b1;
        acc_d      = alu_result_i;
        cnt_d      = cnt_q - SHW'(1);
        if (cnt_q == SHW'(1)) begin
          rsp_data_d = alu_result_i;
          state_d    = ST_RESP;
        end
      end
      ST_RESP: begin
        rsp_valid_o = 1'b1;
`ifdef ALUSEQ_RSP_BYPASS_EN
        req_ready_o = rsp_ready_i;
`endif
        if (rsp_ready_i) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (req_valid_i && req_ready_o) begin
      op_d = req_op_i;
      a_d  = req_a_i;
      b_d  = req_b_i;
      if (is_shift && (req_shamt_i != '0)) begin
        acc_d   = req_a_i;
        cnt_d   = req_shamt_i;
        state_d = ST_SHIFT;
      end else if (is_shift) begin
        cnt_d      = req_shamt_i;
        rsp_data_d = req_a_i;
        state_d    = ST_RESP;
      end else begin
        cnt_d   = req_shamt_i;
        state_d = ST_EXEC;
      end
    end
  end

  assign rsp_data_o = rsp_data_q;
  assign busy_o     = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Front end that drives the team's combinational 16-bit ALU (3-bit Sel, 1-bit shift-in shift, nbit result).
- Accepts operation requests over a valid/ready handshake and drives the ALU operand, select and shin inputs.
- Captures the ALU result and returns it over a second valid/ready handshake.
- ALU shifts move one bit per pass, so multi-bit shifts run as repeated 1-bit passes under a counter.

Parameters:
- NBIT, 16, datapath width; matches the ALU nbit.
- SHW, 4, shift-amount width; max shift 2**SHW-1.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  reset. One clock; reset is asynchronous and active-low.
- req_valid  input  1  request present
- req_ready  output  1  sequencer can accept a request
- req_op  input  3  ALU select code: 000 add, 001 sub, 010, 011, 100, 101 single-pass ops, 110 shl, 111 shr
- req_a  input  NBIT  operand A
- req_b  input  NBIT  operand B (ignored for 101/110/111)
- req_shamt  input  SHW  shift amount for 110/111
- alu_a  output  NBIT  to ALU A
- alu_b  output  NBIT  to ALU B
- alu_sel  output  3  to ALU Sel
- alu_shin  output  1  to ALU shin
- alu_result  input  NBIT  from ALU num_out
- rsp_valid  output  1  result available
- rsp_ready  input  1  consumer accepts result
- rsp_data  output  NBIT  result
- busy  output  1  state != IDLE

Behaviour:
- States: IDLE, EXEC, SHIFT, RESP.
- Reset values (async, immediate on rst_n low): state IDLE, rsp_valid 0, rsp_data 0, busy 0, alu_a/alu_b/alu_sel/alu_shin 0. req_ready is 1 once rst_n is high.
- req_ready = (state==IDLE), combinational from state only.
- Accept = req_valid & req_ready. On accept, latch op, a, b, shamt into internal registers.
- Transitions from accept:
  - op 110/111 with shamt!=0 -> SHIFT; acc<=a, cnt<=shamt.
  - op 110/111 with shamt==0 -> RESP; rsp_data<=a; ALU not driven.
  - any other op -> EXEC.
- EXEC (1 cycle):
  - Drive alu_a=a_reg, alu_b=b_reg, alu_sel=op_reg, alu_shin=0.
  - Register alu_result into rsp_data; -> RESP.
- SHIFT (cnt cycles):
  - Drive alu_a=acc, alu_b=0, alu_sel=op_reg, alu_shin=1.
  - Each cycle: acc<=alu_result, cnt<=cnt-1.
  - When cnt==1: rsp_data<=alu_result; -> RESP.
- RESP:
  - rsp_valid=1; rsp_data held stable until rsp_ready.
  - On rsp_valid & rsp_ready -> IDLE; rsp_valid drops next cycle. rsp_data keeps its last value.
- ALU outputs are driven 0 in IDLE and RESP.
- Latency (accept edge to rsp_valid high):
  - single-pass ops: 2 cycles
  - shift by n>0: n+1 cycles
  - shift by 0: 1 cycle
- rsp_data is whatever alu_result returns; no width or sign adjustment. Sub wraps modulo 2**NBIT.
- Requests arriving while not in IDLE are not accepted. The requester must hold them stable until req_ready.
- rst_n low mid-EXEC/SHIFT/RESP: the operation is discarded with no response and the block re-enters IDLE.

Optional Feature:
- Macro ALUSEQ_RSP_BYPASS_EN.
- Defined: req_ready = (state==IDLE) | (state==RESP & rsp_ready). A request accepted in the same cycle as the response handshake goes directly to EXEC/SHIFT/RESP per the accept rules, skipping IDLE. Sustained single-pass throughput is one result every 2 cycles.
- Undefined: req_ready only in IDLE. Every response costs one IDLE cycle before the next accept.

Test Plan:
- Assert rst_n low during SHIFT of a 15-bit shift -> same cycle: rsp_valid 0, busy 0, alu_* 0. After release, req_ready 1 and no response is ever produced for the killed op.
- op 000, a=0x0005, b=0x0003, rsp_ready=1 -> rsp_valid 2 cycles after accept, rsp_data=0x0008. op 001, a=0x0003, b=0x0005 -> 0xFFFE.
- op 110, a=0x0001, shamt=4 -> alu_shin=1 for exactly 4 cycles, rsp_data=0x0010 at 5 cycles. op 111, a=0x8000, shamt=15 -> 0x0001 at 16 cycles.
- op 110, a=0x1234, shamt=0 -> rsp_data=0x1234 at 1 cycle; alu_sel/alu_shin stay 0 throughout.
- Hold rsp_ready=0 for 3 cycles in RESP with req_valid=1 -> rsp_valid=1, rsp_data stable, req_ready=0. The next request is accepted only after the response handshake plus one IDLE cycle (macro off).
- With ALUSEQ_RSP_BYPASS_EN, stream 4 back-to-back op 100 requests with rsp_ready=1 -> responses every 2 cycles, req_ready high in each RESP cycle, no IDLE cycles between.
